// File: rtl/phy_rx_lane_ctrl_if.sv
// Two-lane PHY receive bus: per-lane byte inputs, sync/active status and assembled word output.
// Optional statistics signals appear when PHY_RX_STATS_EN is defined.
interface phy_rx_lane_ctrl_if;
  logic [7:0]  byte_in_0;
  logic        byte_valid_0;
  logic [7:0]  byte_in_1;
  logic        byte_valid_1;
  logic        sync_0;
  logic        sync_1;
  logic        active;
  logic [31:0] data_out;
  logic        valid_out;
  logic        half_drop;
  logic [1:0]  lane_state;
`ifdef PHY_RX_STATS_EN
  logic [15:0] word_cnt;
  logic [15:0] drop_cnt;

  modport slave (
    input  byte_in_0, byte_valid_0, byte_in_1, byte_valid_1,
    output sync_0, sync_1, active, data_out, valid_out, half_drop, lane_state,
    output word_cnt, drop_cnt
  );
  modport master (
    output byte_in_0, byte_valid_0, byte_in_1, byte_valid_1,
    input  sync_0, sync_1, active, data_out, valid_out, half_drop, lane_state,
    input  word_cnt, drop_cnt
  );
`else
  modport slave (
    input  byte_in_0, byte_valid_0, byte_in_1, byte_valid_1,
    output sync_0, sync_1, active, data_out, valid_out, half_drop, lane_state
  );
  modport master (
    output byte_in_0, byte_valid_0, byte_in_1, byte_valid_1,
    input  sync_0, sync_1, active, data_out, valid_out, half_drop, lane_state
  );
`endif
endinterface

// File: rtl/phy_rx_lane_ctrl.sv
// Two-lane RX sequencer: per-lane comma sync FSM, link-active gating and 32-bit word assembly.
// Optional word/drop statistics counters are enabled by defining PHY_RX_STATS_EN.
module phy_rx_lane_ctrl #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         SYNC_COUNT = 4,
  parameter int         LOSS_COUNT = 4,
  parameter int         CNT_W      = 3
) (
  input logic               clk_4f,
  input logic               reset,
  phy_rx_lane_ctrl_if.slave bus
);

  // Handshake: each lane presents a byte when its byte_valid is high (no backpressure);
  // valid_out and half_drop are single-cycle strobes, data_out is held between strobes.

  typedef enum logic {SEARCH = 1'b0, SYNCED = 1'b1} lane_state_t;

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_COUNT - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_COUNT - 1);

  lane_state_t      state_q    [2];
  lane_state_t      state_d    [2];
  logic [CNT_W-1:0] sync_cnt_q [2];
  logic [CNT_W-1:0] sync_cnt_d [2];
  logic [CNT_W-1:0] loss_cnt_q [2];
  logic [CNT_W-1:0] loss_cnt_d [2];
  logic [7:0]       lane_byte  [2];
  logic             lane_valid [2];

  logic        active_q;
  logic        active_d;
  logic        phase_q;
  logic [15:0] hi_q;
  logic [31:0] data_q;
  logic        valid_q;
  logic        drop_q;
  logic        both_valid;
  logic        idle_cycle;
  logic        data_cycle;

  assign lane_byte[0]  = bus.byte_in_0;
  assign lane_byte[1]  = bus.byte_in_1;
  assign lane_valid[0] = bus.byte_valid_0;
  assign lane_valid[1] = bus.byte_valid_1;

  always_ff @(posedge clk_4f) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        state_q[i]    <= SEARCH;
        sync_cnt_q[i] <= '0;
        loss_cnt_q[i] <= '0;
      end else begin
        state_q[i]    <= state_d[i];
        sync_cnt_q[i] <= sync_cnt_d[i];
        loss_cnt_q[i] <= loss_cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]    = state_q[i];
      sync_cnt_d[i] = sync_cnt_q[i];
      loss_cnt_d[i] = loss_cnt_q[i];
      case (state_q[i])
        SEARCH: begin
          if (lane_valid[i]) begin
            if (lane_byte[i] != COMMA) begin
              sync_cnt_d[i] = '0;
            end else if (sync_cnt_q[i] == SYNC_LAST) begin
              state_d[i]    = SYNCED;
              sync_cnt_d[i] = '0;
              loss_cnt_d[i] = '0;
            end else begin
              sync_cnt_d[i] = sync_cnt_q[i] + 1'b1;
            end
          end
        end
        SYNCED: begin
          if (lane_valid[i]) begin
            loss_cnt_d[i] = '0;
          end else if (loss_cnt_q[i] == LOSS_LAST) begin
            state_d[i]    = SEARCH;
            sync_cnt_d[i] = '0;
            loss_cnt_d[i] = '0;
          end else begin
            loss_cnt_d[i] = loss_cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = SEARCH;
      endcase
    end
  end

  // active tracks the next lane states so it rises and falls on the same edge as sync_x
  assign active_d   = (state_d[0] == SYNCED) && (state_d[1] == SYNCED);
  assign both_valid = lane_valid[0] && lane_valid[1];
  assign idle_cycle = both_valid && (lane_byte[0] == COMMA) && (lane_byte[1] == COMMA);
  assign data_cycle = both_valid && !idle_cycle;

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      hi_q     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
      if (!active_q) begin
        phase_q <= 1'b0;
      end else if (!active_d) begin
        // link going down overrides any data this cycle
        drop_q  <= phase_q;
        phase_q <= 1'b0;
      end else if (idle_cycle) begin
        drop_q  <= phase_q;
        phase_q <= 1'b0;
      end else if (data_cycle) begin
        if (!phase_q) begin
          hi_q    <= {lane_byte[0], lane_byte[1]};
          phase_q <= 1'b1;
        end else begin
          data_q  <= {hi_q, lane_byte[0], lane_byte[1]};
          valid_q <= 1'b1;
          phase_q <= 1'b0;
        end
      end
    end
  end

`ifdef PHY_RX_STATS_EN
  logic [15:0] word_cnt_q;
  logic [15:0] drop_cnt_q;

  // counters advance on the same edge that raises the matching strobe
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      word_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (active_q && active_d && data_cycle && phase_q && (word_cnt_q != 16'hFFFF))
        word_cnt_q <= word_cnt_q + 16'd1;
      if (active_q && phase_q && (!active_d || idle_cycle) && (drop_cnt_q != 16'hFFFF))
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.word_cnt = word_cnt_q;
  assign bus.drop_cnt = drop_cnt_q;
`endif

  assign bus.sync_0     = (state_q[0] == SYNCED);
  assign bus.sync_1     = (state_q[1] == SYNCED);
  assign bus.lane_state = {state_q[1], state_q[0]};
  assign bus.active     = active_q;
  assign bus.data_out   = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.half_drop  = drop_q;

endmodule

// File: tb/tb_phy_rx_lane_ctrl.sv
// Directed bench for phy_rx_lane_ctrl: stimulus pushes expected words/drops into a queue,
// a negedge monitor pops and compares each valid_out / half_drop strobe.
module tb_phy_rx_lane_ctrl;

  logic clk_4f;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic prev_valid;

  // {is_word, is_drop, data}
  logic [33:0] exp_q[$];

  phy_rx_lane_ctrl_if bus();

  phy_rx_lane_ctrl dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus)
  );

  initial begin
    clk_4f = 1'b0;
    forever #5 clk_4f = ~clk_4f;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] b0, input logic v0, input logic [7:0] b1, input logic v1);
    bus.byte_in_0    = b0;
    bus.byte_valid_0 = v0;
    bus.byte_in_1    = b1;
    bus.byte_valid_1 = v1;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back({2'b10, w});
  endtask

  task automatic push_drop();
    exp_q.push_back({2'b01, 32'h0});
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_sync_0"},    {31'h0, bus.sync_0},    32'h0);
    chk({tag, "_sync_1"},    {31'h0, bus.sync_1},    32'h0);
    chk({tag, "_active"},    {31'h0, bus.active},    32'h0);
    chk({tag, "_data_out"},  bus.data_out,           32'h0);
    chk({tag, "_valid_out"}, {31'h0, bus.valid_out}, 32'h0);
    chk({tag, "_half_drop"}, {31'h0, bus.half_drop}, 32'h0);
  endtask

  // scoreboard monitor
  always @(negedge clk_4f) begin
    logic [33:0] e;
    if (bus.valid_out) begin
      n_checks++;
      if (prev_valid) begin
        n_fail++;
        $display("FAIL valid_back_to_back: got 1 expected 0");
      end
    end
    if (bus.valid_out || bus.half_drop) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got valid=%0b drop=%0b data=%h expected none",
                 bus.valid_out, bus.half_drop, bus.data_out);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", {30'h0, bus.valid_out, bus.half_drop}, {30'h0, e[33:32]});
        if (e[33]) chk("word_data", bus.data_out, e[31:0]);
      end
    end
    prev_valid = bus.valid_out;
  end

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    prev_valid       = 1'b0;
    reset            = 1'b1;
    bus.byte_in_0    = 8'h00;
    bus.byte_valid_0 = 1'b0;
    bus.byte_in_1    = 8'h00;
    bus.byte_valid_1 = 1'b0;

    step(8'h00, 1'b0, 8'h00, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0);
    chk_zero_outputs("reset");
`ifdef PHY_RX_STATS_EN
    chk("reset_word_cnt", {16'h0, bus.word_cnt}, 32'h0);
    chk("reset_drop_cnt", {16'h0, bus.drop_cnt}, 32'h0);
`endif
    reset = 1'b0;

    // sync both lanes on four commas
    for (int i = 0; i < 3; i++) step(8'hBC, 1'b1, 8'hBC, 1'b1);
    chk("sync_0_after_3", {31'h0, bus.sync_0}, 32'h0);
    chk("active_after_3", {31'h0, bus.active}, 32'h0);
    step(8'hBC, 1'b1, 8'hBC, 1'b1);
    chk("sync_0_after_4", {31'h0, bus.sync_0}, 32'h1);
    chk("sync_1_after_4", {31'h0, bus.sync_1}, 32'h1);
    chk("active_after_4", {31'h0, bus.active}, 32'h1);
    step(8'hBC, 1'b1, 8'hBC, 1'b1);
    step(8'hBC, 1'b1, 8'hBC, 1'b1);

    // assembly, commas inside a data cycle are data
    step(8'hFF, 1'b1, 8'hBC, 1'b1);
    push_word(32'hFFBCFFEE);
    step(8'hFF, 1'b1, 8'hEE, 1'b1);
    chk("valid_latency", {31'h0, bus.valid_out}, 32'h1);
    step(8'hDD, 1'b1, 8'hCC, 1'b1);
    chk("valid_single_cycle", {31'h0, bus.valid_out}, 32'h0);
    push_word(32'hDDCCBCCC);
    step(8'hBC, 1'b1, 8'hCC, 1'b1);
    step(8'hBC, 1'b1, 8'hBC, 1'b1);
    chk("data_out_hold", bus.data_out, 32'hDDCCBCCC);
    chk("idle_no_valid", {31'h0, bus.valid_out}, 32'h0);

    // idle at phase 1 drops the half-word
    step(8'h00, 1'b1, 8'hBC, 1'b1);
    push_drop();
    step(8'hBC, 1'b1, 8'hBC, 1'b1);
    chk("idle_drop", {31'h0, bus.half_drop}, 32'h1);
    step(8'h07, 1'b1, 8'h00, 1'b1);
    push_word(32'h0700BC08);
    step(8'hBC, 1'b1, 8'h08, 1'b1);

    // a stall at phase 1 holds the pending half
    step(8'h11, 1'b1, 8'h22, 1'b1);
    step(8'h99, 1'b1, 8'h00, 1'b0);
    chk("stall_no_drop", {31'h0, bus.half_drop}, 32'h0);
    push_word(32'h11223344);
    step(8'h33, 1'b1, 8'h44, 1'b1);

    // loss of sync on lane 1 with a pending half
    step(8'hAA, 1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 3; i++) step(8'hBC, 1'b1, 8'h00, 1'b0);
    chk("sync_1_loss_3", {31'h0, bus.sync_1}, 32'h1);
    push_drop();
    step(8'hBC, 1'b1, 8'h00, 1'b0);
    chk("sync_1_loss_4", {31'h0, bus.sync_1}, 32'h0);
    chk("active_loss",   {31'h0, bus.active}, 32'h0);
    chk("sync_0_kept",   {31'h0, bus.sync_0}, 32'h1);
    chk("loss_drop",     {31'h0, bus.half_drop}, 32'h1);

    // recovery needs four fresh commas
    for (int i = 0; i < 3; i++) step(8'hBC, 1'b1, 8'hBC, 1'b1);
    chk("recover_3", {31'h0, bus.sync_1}, 32'h0);
    step(8'hBC, 1'b1, 8'hBC, 1'b1);
    chk("recover_4_sync", {31'h0, bus.sync_1}, 32'h1);
    chk("recover_4_active", {31'h0, bus.active}, 32'h1);
`ifdef PHY_RX_STATS_EN
    chk("word_cnt", {16'h0, bus.word_cnt}, 32'd4);
    chk("drop_cnt", {16'h0, bus.drop_cnt}, 32'd2);
`endif

    // reset mid-word discards without half_drop
    step(8'h12, 1'b1, 8'h34, 1'b1);
    reset = 1'b1;
    step(8'h56, 1'b1, 8'h78, 1'b1);
    chk_zero_outputs("midword_reset");
`ifdef PHY_RX_STATS_EN
    chk("midword_word_cnt", {16'h0, bus.word_cnt}, 32'h0);
    chk("midword_drop_cnt", {16'h0, bus.drop_cnt}, 32'h0);
`endif
    reset = 1'b0;

    // partial sync on lane 0 restarts the comma count
    for (int i = 0; i < 3; i++) step(8'hBC, 1'b1, 8'hBC, 1'b1);
    step(8'h00, 1'b1, 8'hBC, 1'b1);
    chk("partial_sync_0", {31'h0, bus.sync_0}, 32'h0);
    chk("partial_sync_1", {31'h0, bus.sync_1}, 32'h1);
    chk("partial_active", {31'h0, bus.active}, 32'h0);
    for (int i = 0; i < 3; i++) step(8'hBC, 1'b1, 8'hBC, 1'b1);
    chk("partial_3_more", {31'h0, bus.sync_0}, 32'h0);
    step(8'hBC, 1'b1, 8'hBC, 1'b1);
    chk("partial_4_more", {31'h0, bus.sync_0}, 32'h1);
    chk("partial_active_up", {31'h0, bus.active}, 32'h1);

    step(8'hBC, 1'b1, 8'hBC, 1'b1);
    step(8'hBC, 1'b1, 8'hBC, 1'b1);
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phy_rx_lane_ctrl.md
Name: phy_rx_lane_ctrl

Overview:
Sequencing controller for the two-lane PHY receive path. It sits after the per-lane serial-to-parallel converters and runs one sync state machine per lane on the 0xBC comma character. It gates the link active once both lanes are synced, then schedules the lane-0/lane-1 byte pairs into 32-bit words with a valid strobe. It also discards partial words broken by idle or loss of sync.

Parameters:
COMMA, 8'hBC, sync/idle character
SYNC_COUNT, 4, consecutive commas a lane must receive to reach SYNCED
LOSS_COUNT, 4, consecutive byte_valid=0 cycles in SYNCED that force a lane back to SEARCH
CNT_W, 3, width of the per-lane counters; must hold max(SYNC_COUNT, LOSS_COUNT)

Ports:
clk_4f  input  1  byte-rate clock, the only clock; all logic on its rising edge
reset  input  1  synchronous, active-high
byte_in_0  input  8  lane-0 parallel byte
byte_valid_0  input  1  lane-0 byte present this cycle
byte_in_1  input  8  lane-1 parallel byte
byte_valid_1  input  1  lane-1 byte present this cycle
sync_0  output  1  lane 0 in SYNCED
sync_1  output  1  lane 1 in SYNCED
active  output  1  both lanes SYNCED
data_out  output  32  assembled word
valid_out  output  1  one-cycle strobe, data_out holds a new word
half_drop  output  1  one-cycle strobe, a pending half-word was discarded

Behaviour:
- Reset, sampled on the clk_4f edge while high: all outputs 0, both lanes go to SEARCH, counters 0, phase 0, pending half cleared. Reset mid-word discards the half-word without asserting half_drop.
- Lane FSM, per lane, two states:
  - SEARCH: valid comma increments sync_cnt. Any other valid byte clears sync_cnt. A cycle with byte_valid=0 holds sync_cnt.
  - SEARCH to SYNCED: when sync_cnt would reach SYNC_COUNT. sync_x goes to 1 on the edge that samples the SYNC_COUNT-th comma and is visible the following cycle.
  - SYNCED: byte_valid=0 increments loss_cnt, and byte_valid=1 clears it. When loss_cnt reaches LOSS_COUNT, the lane returns to SEARCH and sync_cnt and loss_cnt clear.
- active = sync_0 & sync_1, registered. It uses the same cycle timing as sync_x.
- Cycle classification, valid only while active=1:
  - Idle cycle: both byte_valid are 1 and both bytes equal COMMA.
  - Data cycle: both byte_valid are 1 and at least one byte is not COMMA. A comma on one lane inside a data cycle is data.
  - Stall cycle: either byte_valid is 0. No state change except loss counting.
- Word assembly uses a 1-bit phase.
  - Phase 0 data cycle: hi <= {byte_in_0, byte_in_1}; phase -> 1.
  - Phase 1 data cycle: data_out <= {hi, byte_in_0, byte_in_1}, so lane 0 sits in [31:24] and [15:8]; valid_out=1 next cycle; phase -> 0.
  - Latency: valid_out rises the cycle after the second data cycle.
- data_out holds its last value between strobes. valid_out is never high two consecutive cycles.
- Idle cycle at phase 1: half_drop=1 for one cycle, phase -> 0, no valid_out.
- Idle or stall at phase 0: no action. A stall at phase 1 holds the phase.
- active falling at phase 1: half_drop=1, phase -> 0. The same applies when a lane loses sync on the same cycle as a data cycle: active wins and no word is emitted.
- While active=0: valid_out=0, and byte data is ignored for assembly.

Optional Feature:
PHY_RX_STATS_EN
- Defined: adds outputs word_cnt[15:0] and drop_cnt[15:0].
  - word_cnt increments on each valid_out; drop_cnt increments on each half_drop.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Sync: both lanes send 0xBC with valid=1 for 4 cycles -> sync_0=sync_1=1 after the 4th sampled comma; active=1 the same cycle; valid_out stays 0 on continued commas.
- Partial sync: lane 0 sends BC,BC,BC,0x00,BC -> sync_cnt restarts; sync_0 rises only after 4 further consecutive commas.
- Assembly: active, then cycles (FF,BC), (FF,EE) -> data_out=32'hFFBCFFEE with valid_out=1 one cycle later; then (DD,CC),(BC,CC) -> 32'hDDCCBCCC.
- Drop: active, data cycle (00,BC) then idle (BC,BC) -> half_drop=1, no valid_out; next (07,00),(BC,08) -> 32'h0700BC08.
- Loss: while synced, lane 1 valid=0 for 4 cycles -> sync_1=0 and active=0; a pending half asserts half_drop; recovery needs 4 fresh commas.
- Reset mid-word: after one data cycle assert reset -> all outputs 0 next cycle, half_drop stays 0; with PHY_RX_STATS_EN, counters read 0.
